// File: rtl/esteira_pkg.sv
// Shared definitions for the wine bottling line: ESTADO encoding and default parameters.
// Optional feature macro used by the line: AUTO_REFILL_EN (automatic cork refill).
package esteira_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        MOV_ENCH  = 4'd1,
        ENCHER    = 4'd2,
        VEDAR     = 4'd3,
        MOV_CQ    = 4'd4,
        CQ        = 4'd5,
        MOV_LACRE = 4'd6,
        LACRE     = 4'd7,
        ERRO      = 4'd8
    } estado_t;

    localparam int unsigned DEF_CORK_CAP     = 20;
    localparam int unsigned DEF_CORK_INIT    = 10;
    localparam int unsigned DEF_CORK_ALARM   = 5;
    localparam int unsigned DEF_REFILL_QTY   = 5;
    localparam int unsigned DEF_BATCH_SIZE   = 12;
    localparam int unsigned DEF_DOZ_MAX      = 99;
    localparam int unsigned DEF_FILL_TIMEOUT = 1000;
    localparam int unsigned DEF_CORK_W       = 5;
    localparam int unsigned DEF_BATCH_W      = 4;
    localparam int unsigned DEF_DOZ_W        = 7;

endpackage

// File: rtl/estoque_rolhas.sv
// Cork stock counter with saturation, low-stock alarm and dispenser pulse.
// AUTO_REFILL_EN defined: automatic refill while low; otherwise the dispenser echoes accepted manual adds.
module estoque_rolhas
    import esteira_pkg::*;
#(
    parameter int unsigned CORK_CAP   = DEF_CORK_CAP,
    parameter int unsigned CORK_INIT  = DEF_CORK_INIT,
    parameter int unsigned CORK_ALARM = DEF_CORK_ALARM,
    parameter int unsigned REFILL_QTY = DEF_REFILL_QTY,
    parameter int unsigned CORK_W     = DEF_CORK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seal_dec,
    input  logic              add_rolha,
    output logic [CORK_W-1:0] rolhas,
    output logic              alarme,
    output logic              dispensador
);

    localparam int unsigned SW = CORK_W + 3;

    logic [SW-1:0]     inc;
    logic [SW-1:0]     sum;
    logic [CORK_W-1:0] rolhas_n;
    logic              refill;

    always_comb begin
        refill = 1'b0;
        inc    = '0;
`ifdef AUTO_REFILL_EN
        // dispensador doubles as the "refilled last cycle" flag
        refill = (rolhas < CORK_W'(CORK_ALARM)) && !dispensador;
        if (refill)
            inc = SW'(REFILL_QTY);
        else if (add_rolha)
            inc = SW'(1);
`else
        refill = add_rolha && (rolhas < CORK_W'(CORK_CAP));
        if (add_rolha)
            inc = SW'(1);
`endif
        // add before subtract so a seal plus add at the cap nets to zero
        sum      = SW'(rolhas) + inc - SW'(seal_dec);
        rolhas_n = (sum > SW'(CORK_CAP)) ? CORK_W'(CORK_CAP) : sum[CORK_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rolhas      <= CORK_W'(CORK_INIT);
            alarme      <= (CORK_INIT < CORK_ALARM);
            dispensador <= 1'b0;
        end else begin
            rolhas      <= rolhas_n;
            alarme      <= (rolhas_n < CORK_W'(CORK_ALARM));
            dispensador <= refill;
        end
    end

endmodule

// File: rtl/esteira_envase_param.sv
// Bottling line controller: process/motor FSM, fill timeout, batch and dozen counters.
// Cork handling lives in estoque_rolhas; AUTO_REFILL_EN selects its automatic refill mode.
module esteira_envase_param
    import esteira_pkg::*;
#(
    parameter int unsigned CORK_CAP     = DEF_CORK_CAP,
    parameter int unsigned CORK_INIT    = DEF_CORK_INIT,
    parameter int unsigned CORK_ALARM   = DEF_CORK_ALARM,
    parameter int unsigned REFILL_QTY   = DEF_REFILL_QTY,
    parameter int unsigned BATCH_SIZE   = DEF_BATCH_SIZE,
    parameter int unsigned DOZ_MAX      = DEF_DOZ_MAX,
    parameter int unsigned FILL_TIMEOUT = DEF_FILL_TIMEOUT,
    parameter int unsigned CORK_W       = DEF_CORK_W,
    parameter int unsigned BATCH_W      = DEF_BATCH_W,
    parameter int unsigned DOZ_W        = DEF_DOZ_W
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               KEY_VEDAR,
    input  logic               KEY_ENTER_CQ,
    input  logic               KEY_LACRE,
    input  logic               ADD_ROLHA,
    input  logic               QUALIDADE_OK,
    input  logic               SENSOR_POS_ENCH,
    input  logic               SENSOR_POS_CQ,
    input  logic               SENSOR_POS_LACRE,
    input  logic               SENSOR_CHEIA,
    output logic               MOTOR,
    output logic               VALVULA,
    output logic               ATUADOR_VEDACAO,
    output logic               DISPENSADOR,
    output logic               LED_ALARME_ROLHA,
    output logic               LED_DESCARTE,
    output logic               LED_ERRO,
    output logic [CORK_W-1:0]  ROLHAS,
    output logic [BATCH_W-1:0] GARRAFAS_LOTE,
    output logic [DOZ_W-1:0]   DUZIAS,
    output logic [3:0]         ESTADO
);

    localparam int unsigned TW = (FILL_TIMEOUT > 2) ? $clog2(FILL_TIMEOUT) : 1;

    estado_t            state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic               stop_req, stop_n;
    logic [BATCH_W-1:0] lote_n;
    logic [DOZ_W-1:0]   duz_n;
    logic               seal, reject, eob, running;

    assign ESTADO = state;

    estoque_rolhas #(
        .CORK_CAP   (CORK_CAP),
        .CORK_INIT  (CORK_INIT),
        .CORK_ALARM (CORK_ALARM),
        .REFILL_QTY (REFILL_QTY),
        .CORK_W     (CORK_W)
    ) u_estoque (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .seal_dec    (seal),
        .add_rolha   (ADD_ROLHA),
        .rolhas      (ROLHAS),
        .alarme      (LED_ALARME_ROLHA),
        .dispensador (DISPENSADOR)
    );

    always_comb begin
        state_n = state;
        timer_n = timer;
        stop_n  = stop_req;
        lote_n  = GARRAFAS_LOTE;
        duz_n   = DUZIAS;
        seal    = 1'b0;
        reject  = 1'b0;
        eob     = 1'b0;
        running = (state != IDLE) && (state != ERRO);

        case (state)
            IDLE:      if (START) state_n = MOV_ENCH;
            MOV_ENCH:  if (SENSOR_POS_ENCH) begin
                           state_n = ENCHER;
                           timer_n = '0;
                       end
            ENCHER:    if (SENSOR_CHEIA)
                           state_n = VEDAR;
                       else if (timer == TW'(FILL_TIMEOUT - 1))
                           state_n = ERRO;
                       else
                           timer_n = timer + TW'(1);
            VEDAR:     if (KEY_VEDAR && (ROLHAS != '0)) begin
                           seal    = 1'b1;
                           state_n = MOV_CQ;
                       end
            MOV_CQ:    if (SENSOR_POS_CQ) state_n = CQ;
            CQ:        if (KEY_ENTER_CQ) begin
                           if (QUALIDADE_OK) begin
                               state_n = MOV_LACRE;
                           end else begin
                               reject = 1'b1;
                               eob    = 1'b1;
                           end
                       end
            MOV_LACRE: if (SENSOR_POS_LACRE) state_n = LACRE;
            LACRE:     if (KEY_LACRE) begin
                           eob = 1'b1;
                           if (GARRAFAS_LOTE == BATCH_W'(BATCH_SIZE - 1)) begin
                               lote_n = '0;
                               duz_n  = (DUZIAS == DOZ_W'(DOZ_MAX)) ? '0 : DUZIAS + DOZ_W'(1);
                           end else begin
                               lote_n = GARRAFAS_LOTE + BATCH_W'(1);
                           end
                       end
            ERRO:      if (START) state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        if (eob)
            state_n = stop_req ? IDLE : MOV_ENCH;

        // any return to IDLE starts the next run with no pending stop
        if (START && running)
            stop_n = 1'b1;
        if (state_n == IDLE)
            stop_n = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= IDLE;
            timer           <= '0;
            stop_req        <= 1'b0;
            GARRAFAS_LOTE   <= '0;
            DUZIAS          <= '0;
            MOTOR           <= 1'b0;
            VALVULA         <= 1'b0;
            ATUADOR_VEDACAO <= 1'b0;
            LED_DESCARTE    <= 1'b0;
            LED_ERRO        <= 1'b0;
        end else begin
            state           <= state_n;
            timer           <= timer_n;
            stop_req        <= stop_n;
            GARRAFAS_LOTE   <= lote_n;
            DUZIAS          <= duz_n;
            MOTOR           <= (state_n == MOV_ENCH) || (state_n == MOV_CQ) || (state_n == MOV_LACRE);
            VALVULA         <= (state_n == ENCHER);
            ATUADOR_VEDACAO <= seal;
            LED_DESCARTE    <= reject;
            LED_ERRO        <= (state_n == ERRO);
        end
    end

endmodule

// File: tb/tb_esteira_envase_param.sv
// Bench for esteira_envase_param: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the bottling line.
module tb_esteira_envase_param;
    import esteira_pkg::*;

    localparam int CAP = 20, INIT = 10, ALARM = 5, QTY = 5;
    localparam int BATCH = 12, DMAX = 99, TMO = 1000;

    logic CLK, RESET_N;
    logic START, KEY_VEDAR, KEY_ENTER_CQ, KEY_LACRE, ADD_ROLHA, QUALIDADE_OK;
    logic SENSOR_POS_ENCH, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_CHEIA;
    logic MOTOR, VALVULA, ATUADOR_VEDACAO, DISPENSADOR, LED_ALARME_ROLHA, LED_DESCARTE, LED_ERRO;
    logic [4:0] ROLHAS;
    logic [3:0] GARRAFAS_LOTE;
    logic [6:0] DUZIAS;
    logic [3:0] ESTADO;

    esteira_envase_param dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .KEY_VEDAR(KEY_VEDAR),
        .KEY_ENTER_CQ(KEY_ENTER_CQ), .KEY_LACRE(KEY_LACRE), .ADD_ROLHA(ADD_ROLHA),
        .QUALIDADE_OK(QUALIDADE_OK), .SENSOR_POS_ENCH(SENSOR_POS_ENCH),
        .SENSOR_POS_CQ(SENSOR_POS_CQ), .SENSOR_POS_LACRE(SENSOR_POS_LACRE),
        .SENSOR_CHEIA(SENSOR_CHEIA), .MOTOR(MOTOR), .VALVULA(VALVULA),
        .ATUADOR_VEDACAO(ATUADOR_VEDACAO), .DISPENSADOR(DISPENSADOR),
        .LED_ALARME_ROLHA(LED_ALARME_ROLHA), .LED_DESCARTE(LED_DESCARTE),
        .LED_ERRO(LED_ERRO), .ROLHAS(ROLHAS), .GARRAFAS_LOTE(GARRAFAS_LOTE),
        .DUZIAS(DUZIAS), .ESTADO(ESTADO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0, n_err = 0, n_desc = 0;

    // reference model state
    estado_t m_st;
    int      m_fill, m_rol, m_lote, m_duz;
    bit      m_stop, m_disp_prev;
    bit [6:0] e_flags;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = IDLE; m_fill = 0; m_rol = INIT; m_lote = 0; m_duz = 0;
        m_stop = 0; m_disp_prev = 0;
        e_flags = {4'b0000, (INIT < ALARM) ? 1'b1 : 1'b0, 2'b00};
    endtask

    task automatic model_step();
        estado_t nx;
        bit sealed, rejected, done, refill, running;
        int r;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        nx = m_st; sealed = 0; rejected = 0; done = 0; refill = 0;
        running = (m_st != IDLE) && (m_st != ERRO);
        case (m_st)
            IDLE:      if (START) nx = MOV_ENCH;
            MOV_ENCH:  if (SENSOR_POS_ENCH) begin nx = ENCHER; m_fill = 0; end
            ENCHER: begin
                m_fill++;
                if (SENSOR_CHEIA) nx = VEDAR;
                else if (m_fill >= TMO) nx = ERRO;
            end
            VEDAR:     if (KEY_VEDAR && m_rol > 0) begin sealed = 1; nx = MOV_CQ; end
            MOV_CQ:    if (SENSOR_POS_CQ) nx = CQ;
            CQ:        if (KEY_ENTER_CQ) begin
                           if (QUALIDADE_OK) nx = MOV_LACRE;
                           else begin rejected = 1; done = 1; end
                       end
            MOV_LACRE: if (SENSOR_POS_LACRE) nx = LACRE;
            LACRE:     if (KEY_LACRE) begin
                           done = 1;
                           m_lote++;
                           if (m_lote == BATCH) begin
                               m_lote = 0;
                               m_duz = (m_duz == DMAX) ? 0 : m_duz + 1;
                           end
                       end
            ERRO:      if (START) nx = IDLE;
            default:   nx = IDLE;
        endcase
        if (done) nx = m_stop ? IDLE : MOV_ENCH;
        if (nx == IDLE) m_stop = 0;
        else if (START && running) m_stop = 1;

        r = m_rol - (sealed ? 1 : 0);
`ifdef AUTO_REFILL_EN
        refill = (m_rol < ALARM) && !m_disp_prev;
        if (refill) r += QTY;
        else if (ADD_ROLHA) r += 1;
`else
        refill = ADD_ROLHA && (m_rol < CAP);
        if (ADD_ROLHA) r += 1;
`endif
        if (r > CAP) r = CAP;
        m_disp_prev = refill;
        m_rol = r;
        e_flags = {(nx == MOV_ENCH || nx == MOV_CQ || nx == MOV_LACRE), nx == ENCHER,
                   sealed, refill, r < ALARM, rejected, nx == ERRO};
        m_st = nx;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        if (RESET_N) begin
            chk("estado", 32'(ESTADO), 32'(m_st));
            chk("rolhas", 32'(ROLHAS), m_rol);
            chk("lote", 32'(GARRAFAS_LOTE), m_lote);
            chk("duzias", 32'(DUZIAS), m_duz);
            chk("flags", 32'({MOTOR, VALVULA, ATUADOR_VEDACAO, DISPENSADOR,
                              LED_ALARME_ROLHA, LED_DESCARTE, LED_ERRO}), 32'(e_flags));
            if (LED_DESCARTE) n_desc++;
        end
    endtask

    task automatic clear_inputs();
        START = 0; KEY_VEDAR = 0; KEY_ENTER_CQ = 0; KEY_LACRE = 0; ADD_ROLHA = 0;
        QUALIDADE_OK = 0; SENSOR_POS_ENCH = 0; SENSOR_POS_CQ = 0;
        SENSOR_POS_LACRE = 0; SENSOR_CHEIA = 0;
    endtask

    // one bottle from MOV_ENCH through to end-of-bottle; add_key pairs a manual add with the seal
    task automatic run_bottle(input bit ok, input bit add_key);
        SENSOR_POS_ENCH = 1; tick(); SENSOR_POS_ENCH = 0;
        SENSOR_CHEIA = 1; tick(); SENSOR_CHEIA = 0;
        KEY_VEDAR = 1; ADD_ROLHA = add_key; tick(); KEY_VEDAR = 0; ADD_ROLHA = 0;
        SENSOR_POS_CQ = 1; tick(); SENSOR_POS_CQ = 0;
        KEY_ENTER_CQ = 1; QUALIDADE_OK = ok; tick(); KEY_ENTER_CQ = 0; QUALIDADE_OK = 0;
        if (ok) begin
            SENSOR_POS_LACRE = 1; tick(); SENSOR_POS_LACRE = 0;
            KEY_LACRE = 1; tick(); KEY_LACRE = 0;
        end
    endtask

    initial begin
        int n, d0;
        clear_inputs();
        RESET_N = 0;
        model_reset();
        #23;
        chk("rst_rolhas", 32'(ROLHAS), INIT);
        chk("rst_estado", 32'(ESTADO), 32'(IDLE));
        chk("rst_leds", 32'({LED_ALARME_ROLHA, LED_DESCARTE, LED_ERRO, MOTOR, VALVULA}), 0);
        chk("rst_counts", 32'({GARRAFAS_LOTE, DUZIAS}), 0);
        RESET_N = 1;

        // happy path
        START = 1; tick(); START = 0;
        run_bottle(1, 0);
        chk("hp_rolhas", 32'(ROLHAS), 9);
        chk("hp_lote", 32'(GARRAFAS_LOTE), 1);
        chk("hp_estado", 32'(ESTADO), 32'(MOV_ENCH));

        // complete first batch
        repeat (11) run_bottle(1, 1);
        chk("batch_lote", 32'(GARRAFAS_LOTE), 0);
        chk("batch_duz", 32'(DUZIAS), 1);
        chk("batch_rolhas", 32'(ROLHAS), 9);

        // rejected bottle
        d0 = n_desc;
        run_bottle(0, 1);
        chk("rej_pulse_cycles", n_desc - d0, 1);
        chk("rej_lote", 32'(GARRAFAS_LOTE), 0);

        // dozen counter to its limit and wrap
        repeat (98 * BATCH) run_bottle(1, 1);
        chk("doz_max", 32'(DUZIAS), DMAX);
        repeat (BATCH) run_bottle(1, 1);
        chk("doz_wrap", 32'(DUZIAS), 0);

`ifdef AUTO_REFILL_EN
        repeat (4) run_bottle(1, 0);
        SENSOR_POS_ENCH = 1; tick(); SENSOR_POS_ENCH = 0;
        SENSOR_CHEIA = 1; tick(); SENSOR_CHEIA = 0;
        KEY_VEDAR = 1; tick(); KEY_VEDAR = 0;
        chk("auto_low", 32'(ROLHAS), 4);
        tick();
        chk("auto_disp", 32'(DISPENSADOR), 1);
        chk("auto_rolhas", 32'(ROLHAS), 9);
`else
        repeat (9) run_bottle(1, 0);
        chk("drain_rolhas", 32'(ROLHAS), 0);
        SENSOR_POS_ENCH = 1; tick(); SENSOR_POS_ENCH = 0;
        SENSOR_CHEIA = 1; tick(); SENSOR_CHEIA = 0;
        KEY_VEDAR = 1; tick(); KEY_VEDAR = 0;
        chk("empty_estado", 32'(ESTADO), 32'(VEDAR));
        chk("empty_rolhas", 32'(ROLHAS), 0);
        ADD_ROLHA = 1; tick(); ADD_ROLHA = 0;
        chk("add_disp", 32'(DISPENSADOR), 1);
        KEY_VEDAR = 1; tick(); KEY_VEDAR = 0;
        chk("reseal_estado", 32'(ESTADO), 32'(MOV_CQ));
`endif
        SENSOR_POS_CQ = 1; tick(); SENSOR_POS_CQ = 0;
        KEY_ENTER_CQ = 1; QUALIDADE_OK = 0; tick(); KEY_ENTER_CQ = 0;

        // saturate the cork stock
        ADD_ROLHA = 1; repeat (25) tick(); ADD_ROLHA = 0;
        chk("cap_rolhas", 32'(ROLHAS), CAP);

        // fill timeout
        SENSOR_POS_ENCH = 1; tick(); SENSOR_POS_ENCH = 0;
        n = 0;
        while (!LED_ERRO && n < TMO + 100) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_valvula", 32'(VALVULA), 0);
        chk("tmo_led_erro", 32'(LED_ERRO), 1);
        START = 1; tick(); START = 0;
        chk("erro_to_idle", 32'(ESTADO), 32'(IDLE));

        // asynchronous reset while filling
        START = 1; tick(); START = 0;
        SENSOR_POS_ENCH = 1; tick(); SENSOR_POS_ENCH = 0;
        chk("fill_valvula", 32'(VALVULA), 1);
        #2 RESET_N = 0;
        #1;
        chk("async_valvula", 32'(VALVULA), 0);
        chk("async_estado", 32'(ESTADO), 32'(IDLE));
        chk("async_rolhas", 32'(ROLHAS), INIT);
        tick();
        RESET_N = 1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            START            = ($urandom_range(99) < 3);
            KEY_VEDAR        = ($urandom_range(2) == 0);
            KEY_ENTER_CQ     = ($urandom_range(2) == 0);
            KEY_LACRE        = ($urandom_range(2) == 0);
            ADD_ROLHA        = ($urandom_range(9) == 0);
            QUALIDADE_OK     = ($urandom_range(9) != 0);
            SENSOR_POS_ENCH  = ($urandom_range(1) == 0);
            SENSOR_POS_CQ    = ($urandom_range(1) == 0);
            SENSOR_POS_LACRE = ($urandom_range(1) == 0);
            SENSOR_CHEIA     = ($urandom_range(4) == 0);
            tick();
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
